// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - PC register, next-PC select and 2^ADDR_W x DATA_W registered-read instruction memory
// Optional feature macro: IMEM_WRITE_EN (program-load write port; without it the memory is a zero ROM)
module instr_fetch_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_sel,
    input  logic [DATA_W-1:0] br_target,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] instr_out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] next_pc;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;

    // Word addressing: sequential step is one word; the add wraps at the top of the 32-bit space.
    assign pc_inc  = pc + DATA_W'(1);
    assign next_pc = br_sel ? br_target : pc_inc;
    assign rd_addr = pc[ADDR_W-1:0];

`ifdef IMEM_WRITE_EN
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // The write path ignores rst so a loader can program the memory while the fetch is held in reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_word = mem[rd_addr];
`else
    logic unused_wr_port;

    assign unused_wr_port = ^{wr_en, wr_addr, wr_data, rd_addr, DEPTH[0]};
    assign rd_word        = '0;
`endif

    // Read happens on the same edge as any write, so a colliding write is seen only on the next fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            pc_out    <= '0;
            instr_out <= '0;
        end else begin
            instr_out <= rd_word;
            pc_out    <= pc_inc;
            pc        <= next_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - directed self-checking bench for instr_fetch_mem
module tb_instr_fetch_mem;

    logic        clk;
    logic        rst;
    logic        br_sel;
    logic [31:0] br_target;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pc;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    int n_checks;
    int n_fail;

    instr_fetch_mem #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .br_sel    (br_sel),
        .br_target (br_target),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pc        (pc),
        .pc_out    (pc_out),
        .instr_out (instr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image the bench loads; the ROM build holds zeros everywhere.
    function automatic logic [31:0] exp_word(input int a);
`ifdef IMEM_WRITE_EN
        case (a)
            0:       return 32'h1111_1111;
            1:       return 32'h2222_2222;
            2:       return 32'h3333_3333;
            3:       return 32'h4444_4444;
            5:       return 32'hAAAA_0000;
            16:      return 32'hDEAD_BEEF;
            default: return 32'h0;
        endcase
`else
        return (a < 0) ? 32'h1 : 32'h0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({pc, pc_out, instr_out} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_initial: pc=%h pc_out=%h instr=%h, want all 0", pc, pc_out, instr_out);
        end
        load_word(8'h00, 32'h1111_1111);
        load_word(8'h01, 32'h2222_2222);
        load_word(8'h02, 32'h3333_3333);
        load_word(8'h03, 32'h4444_4444);
        load_word(8'h05, 32'hAAAA_0000);
        load_word(8'h10, 32'hDEAD_BEEF);
        n_checks++;
        if ({pc, pc_out, instr_out} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_held: pc=%h pc_out=%h instr=%h, want all 0", pc, pc_out, instr_out);
        end
    endtask

    task automatic test_sequential();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (pc !== 32'(k) || pc_out !== 32'(k) || instr_out !== exp_word(k - 1)) begin
                n_fail++;
                $display("FAIL seq_edge%0d: pc=%h pc_out=%h instr=%h, want %h %h %h",
                         k, pc, pc_out, instr_out, 32'(k), 32'(k), exp_word(k - 1));
            end
        end
        tick();
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({pc, pc_out, instr_out} !== 96'h0) begin
            n_fail++;
            $display("FAIL async_reset: pc=%h pc_out=%h instr=%h, want all 0", pc, pc_out, instr_out);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++;
        if (pc !== 32'h1 || pc_out !== 32'h1 || instr_out !== exp_word(0)) begin
            n_fail++;
            $display("FAIL reset_release: pc=%h pc_out=%h instr=%h, want 1 1 %h", pc, pc_out, instr_out, exp_word(0));
        end
    endtask

    task automatic test_branch();
        tick();
        n_checks++;
        if (pc !== 32'h2 || pc_out !== 32'h2 || instr_out !== exp_word(1)) begin
            n_fail++;
            $display("FAIL pre_branch: pc=%h pc_out=%h instr=%h, want 2 2 %h", pc, pc_out, instr_out, exp_word(1));
        end
        br_sel    = 1'b1;
        br_target = 32'h10;
        tick();
        br_sel = 1'b0;
        n_checks++;
        if (pc !== 32'h10 || pc_out !== 32'h3 || instr_out !== exp_word(2)) begin
            n_fail++;
            $display("FAIL branch_taken: pc=%h pc_out=%h instr=%h, want 10 3 %h", pc, pc_out, instr_out, exp_word(2));
        end
        tick();
        n_checks++;
        if (pc !== 32'h11 || pc_out !== 32'h11 || instr_out !== exp_word(16)) begin
            n_fail++;
            $display("FAIL branch_fetch: pc=%h pc_out=%h instr=%h, want 11 11 %h", pc, pc_out, instr_out, exp_word(16));
        end
    endtask

    task automatic test_wrap();
        br_sel    = 1'b1;
        br_target = 32'hFF;
        tick();
        br_sel = 1'b0;
        n_checks++;
        if (pc !== 32'hFF || pc_out !== 32'h12) begin
            n_fail++;
            $display("FAIL wrap_to_ff: pc=%h pc_out=%h, want ff 12", pc, pc_out);
        end
        tick();
        n_checks++;
        if (pc !== 32'h100 || pc_out !== 32'h100 || instr_out !== exp_word(255)) begin
            n_fail++;
            $display("FAIL wrap_0x100: pc=%h pc_out=%h instr=%h, want 100 100 %h", pc, pc_out, instr_out, exp_word(255));
        end
        tick();
        n_checks++;
        if (pc !== 32'h101 || pc_out !== 32'h101 || instr_out !== exp_word(0)) begin
            n_fail++;
            $display("FAIL alias_fetch: pc=%h pc_out=%h instr=%h, want 101 101 %h", pc, pc_out, instr_out, exp_word(0));
        end
        br_sel    = 1'b1;
        br_target = 32'hFFFF_FFFF;
        tick();
        br_sel = 1'b0;
        n_checks++;
        if (pc !== 32'hFFFF_FFFF || pc_out !== 32'h102 || instr_out !== exp_word(1)) begin
            n_fail++;
            $display("FAIL branch_top: pc=%h pc_out=%h instr=%h, want ffffffff 102 %h", pc, pc_out, instr_out, exp_word(1));
        end
        tick();
        n_checks++;
        if (pc !== 32'h0 || pc_out !== 32'h0 || instr_out !== exp_word(255)) begin
            n_fail++;
            $display("FAIL pc_wrap32: pc=%h pc_out=%h instr=%h, want 0 0 %h", pc, pc_out, instr_out, exp_word(255));
        end
        tick();
        n_checks++;
        if (pc !== 32'h1 || pc_out !== 32'h1 || instr_out !== exp_word(0)) begin
            n_fail++;
            $display("FAIL after_wrap32: pc=%h pc_out=%h instr=%h, want 1 1 %h", pc, pc_out, instr_out, exp_word(0));
        end
    endtask

    task automatic test_collision();
        logic [31:0] new_word;
`ifdef IMEM_WRITE_EN
        new_word = 32'h5555_FFFF;
`else
        new_word = exp_word(5);
`endif
        br_sel    = 1'b1;
        br_target = 32'h5;
        tick();
        n_checks++;
        if (pc !== 32'h5 || pc_out !== 32'h2 || instr_out !== exp_word(1)) begin
            n_fail++;
            $display("FAIL coll_setup: pc=%h pc_out=%h instr=%h, want 5 2 %h", pc, pc_out, instr_out, exp_word(1));
        end
        wr_en   = 1'b1;
        wr_addr = 8'h05;
        wr_data = 32'h5555_FFFF;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (pc !== 32'h5 || pc_out !== 32'h6 || instr_out !== exp_word(5)) begin
            n_fail++;
            $display("FAIL read_first: pc=%h pc_out=%h instr=%h, want 5 6 %h", pc, pc_out, instr_out, exp_word(5));
        end
        for (int r = 0; r < 2; r++) begin
            tick();
            n_checks++;
            if (pc !== 32'h5 || pc_out !== 32'h6 || instr_out !== new_word) begin
                n_fail++;
                $display("FAIL refetch%0d: pc=%h pc_out=%h instr=%h, want 5 6 %h", r, pc, pc_out, instr_out, new_word);
            end
        end
        br_sel = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        br_sel    = 1'b0;
        br_target = 32'h0;
        wr_en     = 1'b0;
        wr_addr   = 8'h0;
        wr_data   = 32'h0;
        test_reset();
        test_sequential();
        test_async_reset();
        test_branch();
        test_wrap();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
